// File: rtl/score_ctrl.sv
// score_ctrl: match sequencer for a two-player rally game.
// Tracks both scores, gates the physics frame tick, and walks the match
// through IDLE -> PLAY -> PAUSE/OVER using edges of the start button and of
// the physics engine's rally-end flag.
module score_ctrl #(
    parameter int unsigned WIN_SCORE    = 7,   // points needed to win, 1..15
    parameter int unsigned PAUSE_FRAMES = 90   // frame ticks between rallies, 1..1023
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       en,
    input  logic       start_btn,
    input  logic       game_over,
    input  logic [1:0] winner,
    output logic       phys_en,
    output logic [3:0] p1_score,
    output logic [3:0] p2_score,
    output logic [1:0] state,
    output logic [1:0] match_winner,
    output logic       point_pulse
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_PLAY  = 2'd1,
        ST_PAUSE = 2'd2,
        ST_OVER  = 2'd3
    } state_t;

    localparam logic [3:0] WIN_VAL    = 4'(WIN_SCORE);
    localparam logic [9:0] PAUSE_LOAD = 10'(PAUSE_FRAMES);

    state_t     state_q, state_d;
    logic [3:0] p1_q, p1_d;
    logic [3:0] p2_q, p2_d;
    logic [1:0] mw_q, mw_d;
    logic       pulse_q, pulse_d;
    logic [9:0] pause_cnt_q, pause_cnt_d;
    logic       start_prev_q;
    logic       go_prev_q;

    logic       start_edge;
    logic       go_edge;
    logic       valid_winner;
    logic [3:0] p1_inc;
    logic [3:0] p2_inc;
    logic       scorer_wins;

    // Edge detection and scoring helpers shared by the next-state logic.
    assign start_edge   = start_btn & ~start_prev_q;
    assign go_edge      = game_over & ~go_prev_q;
    assign valid_winner = (winner == 2'd1) || (winner == 2'd2);
    assign p1_inc       = p1_q + 4'd1;
    assign p2_inc       = p2_q + 4'd1;
    assign scorer_wins  = (winner == 2'd1) ? (p1_inc == WIN_VAL) : (p2_inc == WIN_VAL);

    // State register: synchronous reset aborts any match in progress.
    // NOTE: sequential state uses non-blocking (<=) so every register samples
    // the pre-edge values; blocking here would create order-dependent races.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            p1_q         <= '0;
            p2_q         <= '0;
            mw_q         <= 2'd0;
            pulse_q      <= 1'b0;
            pause_cnt_q  <= '0;
            start_prev_q <= 1'b0;
            go_prev_q    <= 1'b0;
        end else begin
            state_q      <= state_d;
            p1_q         <= p1_d;
            p2_q         <= p2_d;
            mw_q         <= mw_d;
            pulse_q      <= pulse_d;
            pause_cnt_q  <= pause_cnt_d;
            start_prev_q <= start_btn;
            go_prev_q    <= game_over;
        end
    end

    // Next-state logic: match sequencing, scoring and the pause countdown.
    // NOTE: every variable gets a default before the case so no path leaves
    // one unassigned, which would otherwise infer a latch.
    always_comb begin
        state_d     = state_q;
        p1_d        = p1_q;
        p2_d        = p2_q;
        mw_d        = mw_q;
        pulse_d     = 1'b0;
        pause_cnt_d = pause_cnt_q;

        unique case (state_q)
            ST_IDLE, ST_OVER: begin
                // A start begins a fresh match; a simultaneous rally end is moot.
                if (start_edge) begin
                    state_d = ST_PLAY;
                    p1_d    = '0;
                    p2_d    = '0;
                    mw_d    = 2'd0;
                end
            end
            ST_PLAY: begin
                // Start presses are ignored mid-match; invalid winners are dropped.
                if (go_edge && valid_winner) begin
                    pulse_d = 1'b1;
                    if (winner == 2'd1) begin
                        p1_d = p1_inc;
                    end else begin
                        p2_d = p2_inc;
                    end
                    if (scorer_wins) begin
                        state_d = ST_OVER;
                        mw_d    = winner;
                    end else begin
                        state_d     = ST_PAUSE;
                        pause_cnt_d = PAUSE_LOAD;
                    end
                end
            end
            ST_PAUSE: begin
                // Count frames down; the frame that consumes the last one resumes play.
                if (en) begin
                    pause_cnt_d = pause_cnt_q - 10'd1;
                    if (pause_cnt_q == 10'd1) begin
                        state_d = ST_PLAY;
                    end
                end
            end
            default: ;
        endcase
    end

    // Physics tick gating follows the current (pre-transition) state with no latency.
    always_comb begin
        phys_en = 1'b0;
        unique case (state_q)
            ST_PLAY:  phys_en = en;
            ST_PAUSE: phys_en = en & game_over;
            default:  phys_en = 1'b0;
        endcase
    end

    assign p1_score     = p1_q;
    assign p2_score     = p2_q;
    assign state        = state_q;
    assign match_winner = mw_q;
    assign point_pulse  = pulse_q;

endmodule

// File: doc/score_ctrl.md
SCORE_CTRL -- requirements
Module: score_ctrl

Interface
REQ-001 Parameter WIN_SCORE, default 7, is the points needed to win the match; legal range 1..15.
REQ-002 Parameter PAUSE_FRAMES, default 90, is the number of frame ticks in the between-rally pause; legal range 1..1023.
REQ-003 clk  input  1  system clock; the only clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; synchronous, active-high.
REQ-005 en  input  1  60 Hz frame tick, one clk wide.
REQ-006 start_btn  input  1  level start/restart button, already debounced.
REQ-007 game_over  input  1  rally-end flag from the physics engine.
REQ-008 winner  input  2  rally winner from the physics engine: 1 = P1, 2 = P2, 0 and 3 are invalid.
REQ-009 phys_en  output  1  gated frame tick that drives the physics engine's en input.
REQ-010 p1_score  output  4  P1 points.
REQ-011 p2_score  output  4  P2 points.
REQ-012 state  output  2  match state: 0 = IDLE, 1 = PLAY, 2 = PAUSE, 3 = OVER.
REQ-013 match_winner  output  2  0 = none, 1 = P1, 2 = P2.
REQ-014 point_pulse  output  1  one-clk pulse when a point is scored.

Function
REQ-015 Rising edges of start_btn and game_over shall be detected with one register each, sampled every clk; start_edge = start_btn & ~start_btn_d and go_edge = game_over & ~game_over_d.
REQ-016 phys_en shall be combinational, with no added latency: en in PLAY; en & game_over in PAUSE, so physics can clear its flag and respawn the ball; 0 in IDLE and OVER.
REQ-017 IDLE: on start_edge -> PLAY; clear both scores and match_winner in the same cycle.
REQ-018 PLAY: on go_edge with winner==1, increment p1_score; with winner==2, increment p2_score; with winner 0 or 3, ignore the edge and stay in PLAY with no pulse.
REQ-019 On a counted point, point_pulse shall be 1 in the clk after go_edge is sampled, aligned with the score update.
REQ-020 If the incremented score equals WIN_SCORE -> OVER and set match_winner to the scorer; otherwise -> PAUSE and load pause_cnt with PAUSE_FRAMES.
REQ-021 PAUSE: decrement pause_cnt (10 bits) on each en; on an en with pause_cnt==1 -> PLAY; go_edge is ignored in PAUSE.
REQ-022 OVER: hold scores and match_winner; on start_edge -> PLAY, clear scores and match_winner.
REQ-023 start_edge in PLAY or PAUSE shall be ignored.
REQ-024 Scores shall never exceed WIN_SCORE; no wrap-around is possible because OVER is entered at WIN_SCORE.
REQ-025 If go_edge and start_edge occur in the same cycle, the state-specific rule applies: in PLAY score the point; in IDLE/OVER start the match and ignore go_edge.
REQ-026 If en and the PLAY->PAUSE transition occur in the same clk, phys_en shall follow the pre-transition state (PLAY).

Reset
REQ-027 While rst=1 at a clk edge: state=IDLE, p1_score=0, p2_score=0, match_winner=0, point_pulse=0, pause_cnt=0, and both edge registers=0.
REQ-028 Reset asserted in any state, including mid-PAUSE, shall take effect at the next clk edge and abort the match; phys_en=0 in the cycle after reset.
REQ-029 The edge registers clear to 0, so a start_btn held high through reset produces a start_edge in the first cycle after reset.

Verification
REQ-030 Reset, then start_btn high for 3 clk -> state=1 next clk, scores 0/0, phys_en pulses with en.
REQ-031 In PLAY, pulse game_over high with winner=2 -> next clk p2_score=1, point_pulse=1 for one clk, state=2; phys_en passes en only while game_over=1; after 90 en ticks, state=1.
REQ-032 In PLAY, raise game_over with winner=0 -> scores unchanged, no point_pulse, state stays 1.
REQ-033 With WIN_SCORE=7 and p1_score=6, a P1 rally win -> p1_score=7, match_winner=1, state=3, phys_en=0; a later start_edge -> state=1, scores 0/0, match_winner=0.
REQ-034 game_over held high for 200 clk in PLAY -> exactly one point is counted.
REQ-035 rst asserted with pause_cnt=40 in PAUSE -> next clk state=0, scores 0, pause_cnt 0, phys_en=0.
